// File: rtl/multi_slow_clk.sv
// Multi-channel slow-clock tick/PWM generator.
// Double-buffered config, applied only at a channel's period boundary.
module multi_slow_clk #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CHW         = 1
) (
  input  logic                original_clk,
  input  logic                reset,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_duty,
  input  logic                cfg_mode,
  input  logic                cfg_en,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pwm
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_q, duty_d;
  logic [CHANNELS-1:0]            mode_q, mode_d;
  logic [CHANNELS-1:0]            en_q, en_d;

  logic             pend_vld_q, pend_vld_d;
  logic [CHW-1:0]   pend_ch_q, pend_ch_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_en_q, pend_en_d;
  logic             rdy_q, rdy_d;

  logic                accept;
  logic                drop;
  logic [CHANNELS-1:0] apply_v;

  assign cfg_ready = rdy_q;

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    duty_d  = duty_q;
    mode_d  = mode_q;
    en_d    = en_q;
    apply_v = '0;
    tick    = '0;
    pwm     = '0;
    accept  = cfg_valid & rdy_q;
    drop    = pend_vld_q & (int'(pend_ch_q) >= CHANNELS);

    for (int i = 0; i < CHANNELS; i++) begin
      // outputs gated by reset so they fall without waiting for an edge
      tick[i] = ~reset & en_q[i] & (cnt_q[i] == div_q[i]);
      pwm[i]  = ~reset & en_q[i] & mode_q[i]
                & (cnt_q[i] < duty_q[i]);
      apply_v[i] = pend_vld_q & (int'(pend_ch_q) == i)
                   & (sync | ~en_q[i] | (cnt_q[i] >= div_q[i]));
      if (apply_v[i]) begin
        cnt_d[i]  = '0;
        div_d[i]  = pend_div_q;
        duty_d[i] = pend_duty_q;
        mode_d[i] = pend_mode_q;
        en_d[i]   = pend_en_q;
      end else if (~en_q[i] | sync | (cnt_q[i] >= div_q[i])) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end

    pend_vld_d  = pend_vld_q;
    pend_ch_d   = pend_ch_q;
    pend_div_d  = pend_div_q;
    pend_duty_d = pend_duty_q;
    pend_mode_d = pend_mode_q;
    pend_en_d   = pend_en_q;
    if (drop | (|apply_v)) pend_vld_d = 1'b0;
    if (accept) begin
      pend_vld_d  = 1'b1;
      pend_ch_d   = cfg_ch;
      pend_div_d  = cfg_div;
      pend_duty_d = cfg_duty;
      pend_mode_d = cfg_mode;
      pend_en_d   = cfg_en;
    end

    // ready returns one cycle after the slot empties
    rdy_d = rdy_q;
    if (accept) rdy_d = 1'b0;
    else if (~rdy_q & ~pend_vld_q) rdy_d = 1'b1;
  end

  always_ff @(posedge original_clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      div_q       <= {CHANNELS{DEF_DIV}};
      duty_q      <= '0;
      mode_q      <= '0;
      en_q        <= '1;
      pend_vld_q  <= 1'b0;
      pend_ch_q   <= '0;
      pend_div_q  <= '0;
      pend_duty_q <= '0;
      pend_mode_q <= 1'b0;
      pend_en_q   <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      duty_q      <= duty_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
      pend_vld_q  <= pend_vld_d;
      pend_ch_q   <= pend_ch_d;
      pend_div_q  <= pend_div_d;
      pend_duty_q <= pend_duty_d;
      pend_mode_q <= pend_mode_d;
      pend_en_q   <= pend_en_d;
      rdy_q       <= rdy_d;
    end
  end

endmodule

// File: tb/tb_multi_slow_clk.sv
// Randomized bench for multi_slow_clk against a period/phase model.
// Includes reset-release tick timing and async reset with pending word.
module tb_multi_slow_clk;

  localparam int CH  = 3;
  localparam int W   = 8;
  localparam int DD  = 2;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [W-1:0]  cfg_duty;
  logic          cfg_mode;
  logic          cfg_en;
  logic [CH-1:0] tick;
  logic [CH-1:0] pwm;

  always #5 clk = ~clk;

  multi_slow_clk #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DD), .CHW(CHW)
  ) dut (
    .original_clk(clk), .reset(rst), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_duty(cfg_duty),
    .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .tick(tick), .pwm(pwm)
  );

  int errs = 0;
  int checks = 0;

  // model: phase within period, active config, one pending word
  int m_ph[CH];
  int m_div[CH];
  int m_duty[CH];
  bit m_mode[CH];
  bit m_en[CH];
  bit m_pv;
  bit m_rdy;
  int m_pch, m_pdiv, m_pduty;
  bit m_pmode, m_pen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < CH; i++) begin
      m_ph[i] = 0; m_div[i] = DD; m_duty[i] = 0;
      m_mode[i] = 0; m_en[i] = 1;
    end
    m_pv = 0;
    m_rdy = 1;
  endfunction

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] v = '0;
    for (int i = 0; i < CH; i++)
      v[i] = m_en[i] && (m_ph[i] == m_div[i]);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_pwm();
    logic [CH-1:0] v = '0;
    for (int i = 0; i < CH; i++)
      v[i] = m_en[i] && m_mode[i] && (m_ph[i] < m_duty[i]);
    return v;
  endfunction

  // advance model by one edge using the inputs seen on that edge
  function automatic void mstep();
    bit acc = cfg_valid && m_rdy;
    bit was_pv = m_pv;
    bit done = 0;
    for (int i = 0; i < CH; i++) begin
      bit boundary = sync || !m_en[i] || (m_ph[i] == m_div[i]);
      if (m_pv && m_pch == i && boundary) begin
        m_div[i] = m_pdiv; m_duty[i] = m_pduty;
        m_mode[i] = m_pmode; m_en[i] = m_pen;
        m_ph[i] = 0; done = 1;
      end else if (!m_en[i] || sync) begin
        m_ph[i] = 0;
      end else begin
        m_ph[i] = (m_ph[i] + 1) % (m_div[i] + 1);
      end
    end
    if (m_pv && (m_pch >= CH || done)) m_pv = 0;
    if (acc) begin
      m_pv = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
      m_pduty = int'(cfg_duty); m_pmode = cfg_mode; m_pen = cfg_en;
      m_rdy = 0;
    end else if (!m_rdy && !was_pv) begin
      m_rdy = 1;
    end
  endfunction

  task automatic cyc();
    chk("tick", 32'(tick), 32'(exp_tick()));
    chk("pwm", 32'(pwm), 32'(exp_pwm()));
    chk("ready", 32'(cfg_ready), 32'(m_rdy));
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  task automatic idle_in();
    sync = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
    cfg_duty = '0; cfg_mode = 0; cfg_en = 0;
  endtask

  task automatic rand_in();
    sync      = ($urandom_range(0, 19) == 0);
    cfg_valid = ($urandom_range(0, 3) == 0);
    cfg_ch    = CHW'($urandom_range(0, 3));
    cfg_div   = W'($urandom_range(0, 6));
    cfg_duty  = W'($urandom_range(0, 9));
    cfg_mode  = 1'($urandom_range(0, 1));
    cfg_en    = ($urandom_range(0, 3) != 0);
  endtask

  // fixed-constant check of the legacy tick cadence after release
  task automatic release_check(input string tag);
    for (int c = 0; c < 9; c++) begin
      chk(tag, 32'(tick), (c % 3 == DD) ? 32'h7 : 32'h0);
      chk({tag, "_pwm"}, 32'(pwm), 32'h0);
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    mreset();
    #12;
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pwm", 32'(pwm), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    release_check("rel_tick");

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        // capture a word, then reset mid-period while it is pending
        idle_in();
        while (!m_rdy) cyc();
        cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 8'd5;
        cfg_duty = 8'd3; cfg_mode = 1; cfg_en = 1;
        cyc();
        idle_in();
        chk("pend_ready", 32'(cfg_ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_pwm", 32'(pwm), 32'h0);
        chk("arst_ready", 32'(cfg_ready), 32'h1);
        mreset();
        @(negedge clk);
        rst = 1'b0;
        release_check("arel_tick");
      end
      rand_in();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
